// File: rtl/adc_pkg.sv
// Shared types for the ADC sample averager.
package adc_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } avg_state_e;

endpackage : adc_pkg

// File: rtl/sync_rise_detect.sv
// Synchronises an asynchronous level and emits a one-cycle pulse on its rising edge.
module sync_rise_detect #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;
  logic              rise_q;

  // Everything resets to the "already high" level, so an input held high through
  // reset never looks like an edge; only a fresh low->high transition fires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      last_q <= 1'b1;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_i};
      last_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~last_q;
    end
  end

  assign rise_o = rise_q;

endmodule : sync_rise_detect

// File: rtl/adc_sample_averager.sv
// Averages 2**AVG_LOG2 synchronised SAR samples and offers each result on a valid/ready port.
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int RESOLUTION  = 12,
  parameter int AVG_LOG2    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  clear_i,
  input  logic [RESOLUTION-1:0] sample_i,
  input  logic                  sample_rdy_i,
  output logic [RESOLUTION-1:0] avg_o,
  output logic                  avg_valid_o,
  input  logic                  avg_ready_i,
  output logic                  overrun_o
);

  localparam int ACC_W = RESOLUTION + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

  avg_state_e             state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_sum, acc_shifted;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RESOLUTION-1:0]  result;
  logic                   cap;
  logic                   win_done;
  logic                   handshake;

  sync_rise_detect #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (sample_rdy_i),
    .rise_o  (cap)
  );

  // sample_i is still held by the SAR on the cap cycle, so it is summed directly.
  assign acc_sum     = acc_q + ACC_W'(sample_i);
  assign acc_shifted = acc_sum >> AVG_LOG2;
  assign result      = acc_shifted[RESOLUTION-1:0];
  assign handshake   = avg_valid_o && avg_ready_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    win_done = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en_i) state_d = ACCUM;
      end
      ACCUM: begin
        if (!en_i) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end else if (cap && !clear_i) begin
          if (cnt_q == CNT_MAX) begin
            win_done = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A finished window only lands if the slot is empty or being drained this cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avg_o       <= '0;
      avg_valid_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (win_done && (!avg_valid_o || handshake)) begin
        avg_o       <= result;
        avg_valid_o <= 1'b1;
      end else if (handshake) begin
        avg_valid_o <= 1'b0;
      end
      if (clear_i) begin
        overrun_o <= 1'b0;
      end else if (win_done && avg_valid_o && !handshake) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule : adc_sample_averager

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench: three averager instances (AVG_LOG2 = 2, 4, 0) share stimulus, gated by en.
module tb_adc_sample_averager;

  localparam int RES = 12;
  localparam int N   = 3;

  typedef struct {
    int inst;
    int value;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           rdy;
  logic           ready;
  logic [RES-1:0] sample;
  logic           en    [N];
  logic [RES-1:0] avg   [N];
  logic           valid [N];
  logic           ovr   [N];

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    adc_sample_averager #(
      .RESOLUTION  (RES),
      .AVG_LOG2    ((g == 0) ? 2 : (g == 1) ? 4 : 0),
      .SYNC_STAGES (2)
    ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en[g]),
      .clear_i      (clear),
      .sample_i     (sample),
      .sample_rdy_i (rdy),
      .avg_o        (avg[g]),
      .avg_valid_o  (valid[g]),
      .avg_ready_i  (ready),
      .overrun_o    (ovr[g])
    );
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push(input int inst, input int value);
    exp_t x;
    x.inst  = inst;
    x.value = value;
    exp_q.push_back(x);
  endtask

  // One SAR conversion: done level high for 5 cycles, then low for 4.
  task automatic send(input int v);
    sample = RES'(v);
    rdy    = 1'b1;
    repeat (5) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (valid[i] && ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: inst %0d gave %0d, expected nothing", i, avg[i]);
          end else begin
            e = exp_q.pop_front();
            check("out_inst", i, e.inst);
            check("out_avg", int'(avg[i]), e.value);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; rdy = 1'b0; ready = 1'b1; sample = '0;
    for (int i = 0; i < N; i++) en[i] = 1'b0;
    tick(3);
    check("rst_avg", int'(avg[0]), 0);
    check("rst_valid", int'(valid[0]), 0);
    check("rst_overrun", int'(ovr[0]), 0);
    rst = 1'b0;
    tick(2);

    // 1: 100..103 -> 101, valid exactly one cycle after the 4th cap
    en[0] = 1'b1;
    tick(1);
    send(100); send(101); send(102);
    push(0, 101);
    sample = RES'(103);
    rdy    = 1'b1;
    tick(3);
    check("t1_not_yet_valid", int'(valid[0]), 0);
    tick(1);
    check("t1_valid_latency", int'(valid[0]), 1);
    tick(1);
    rdy = 1'b0;
    tick(4);
    en[0] = 1'b0;

    // 2: 16x full scale then 16x zero on the 16-sample instance
    en[1] = 1'b1;
    tick(1);
    push(1, 4095);
    repeat (16) send(4095);
    push(1, 0);
    repeat (16) send(0);
    en[1] = 1'b0;

    // 3: stalled consumer over two windows -> first kept, overrun set
    en[0] = 1'b1;
    ready = 1'b0;
    tick(1);
    push(0, 10);
    repeat (4) send(10);
    repeat (4) send(20);
    check("t3_avg_held", int'(avg[0]), 10);
    check("t3_valid_held", int'(valid[0]), 1);
    check("t3_overrun", int'(ovr[0]), 1);
    ready = 1'b1;
    tick(1);
    check("t3_one_handshake", int'(valid[0]), 0);
    check("t3_overrun_sticky", int'(ovr[0]), 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("t3_overrun_cleared", int'(ovr[0]), 0);

    // 4: window completes in the same cycle as a handshake
    ready = 1'b0;
    push(0, 30);
    repeat (4) send(30);
    push(0, 40);
    repeat (3) send(40);
    sample = RES'(40);
    rdy    = 1'b1;
    tick(3);
    ready = 1'b1;
    tick(1);
    check("t4_valid_stays", int'(valid[0]), 1);
    check("t4_new_avg", int'(avg[0]), 40);
    check("t4_no_overrun", int'(ovr[0]), 0);
    tick(1);
    rdy = 1'b0;
    tick(4);

    // 5: reset mid-window with the done level held high
    send(50); send(50);
    sample = RES'(77);
    rdy    = 1'b1;
    tick(5);
    rst = 1'b1;
    #2;
    check("t5_rst_avg", int'(avg[0]), 0);
    check("t5_rst_valid", int'(valid[0]), 0);
    check("t5_rst_overrun", int'(ovr[0]), 0);
    tick(1);
    rst = 1'b0;
    tick(10);
    rdy = 1'b0;
    tick(4);
    push(0, 9);
    send(8); send(8); send(8);
    check("t5_needs_4_fresh", int'(valid[0]), 0);
    send(12);

    // 6: en_i=0 mid-window, then clear_i coinciding with a cap
    send(100); send(100);
    en[0] = 1'b0;
    tick(2);
    send(200);
    en[0] = 1'b1;
    tick(1);
    push(0, 4);
    repeat (4) send(4);
    send(60); send(60);
    sample = RES'(1000);
    rdy    = 1'b1;
    tick(3);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    rdy = 1'b0;
    tick(4);
    push(0, 16);
    repeat (4) send(16);
    en[0] = 1'b0;

    // AVG_LOG2=0: every sample passes straight through
    en[2] = 1'b1;
    tick(1);
    push(2, 7);    send(7);
    push(2, 4095); send(4095);
    push(2, 0);    send(0);
    en[2] = 1'b0;

    tick(5);
    check("drain_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_adc_sample_averager
